// File: rtl/sound_pkg.sv
// Shared definitions for the 68k <-> Z80 sound mailbox.
package sound_pkg;

  localparam int         OVR_W_DEF    = 4;
  localparam logic [7:0] CMD_INIT_DEF = 8'h00;

  // Mailbox status flags kept together as one register.
  typedef struct packed {
    logic pending;  // command written, not yet read by the Z80
    logic fresh;    // reply written, not yet read by the 68k
    logic nmi_en;   // Z80 has NMI delivery enabled
  } mb_status_t;

endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for a level strobe: one-cycle event per low-to-high
// transition. History clears on reset, so a strobe held high through reset
// release produces one event on the first clock.
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic evt
);

  logic prev_q;
  logic prev_d;

  // Next history is simply the current level.
  always_comb begin
    prev_d = strobe;
  end

  // History register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign evt = strobe & ~prev_q;

endmodule

// File: rtl/sound_mailbox.sv
// Bidirectional byte mailbox between the 68k main CPU and the Z80 sound CPU.
// Holds the command/reply latches, status flags, overrun counter and the
// registered active-low NMI to the Z80.
module sound_mailbox
  import sound_pkg::*;
#(
  parameter int         OVR_W    = OVR_W_DEF,
  parameter logic [7:0] CMD_INIT = CMD_INIT_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             M68K_WR,
  input  logic [7:0]       M68K_DIN,
  input  logic             M68K_RD,
  output logic [7:0]       M68K_DOUT,
  input  logic             Z80_CMD_RD,
  output logic [7:0]       Z80_CMD,
  input  logic             Z80_REPLY_WR,
  input  logic [7:0]       Z80_DIN,
  input  logic             Z80_NMI_EN,
  input  logic             Z80_NMI_DIS,
  output logic             nZ80NMI,
  output logic             CMD_PENDING,
  output logic             REPLY_FRESH,
  output logic [OVR_W-1:0] OVERRUN
);

  logic ev_m68k_wr, ev_m68k_rd, ev_z80_rd, ev_z80_wr, ev_nmi_en, ev_nmi_dis;

  strobe_edge u_edge_m68k_wr (.clk(CLK), .rst(RESET), .strobe(M68K_WR),      .evt(ev_m68k_wr));
  strobe_edge u_edge_m68k_rd (.clk(CLK), .rst(RESET), .strobe(M68K_RD),      .evt(ev_m68k_rd));
  strobe_edge u_edge_z80_rd  (.clk(CLK), .rst(RESET), .strobe(Z80_CMD_RD),   .evt(ev_z80_rd));
  strobe_edge u_edge_z80_wr  (.clk(CLK), .rst(RESET), .strobe(Z80_REPLY_WR), .evt(ev_z80_wr));
  strobe_edge u_edge_nmi_en  (.clk(CLK), .rst(RESET), .strobe(Z80_NMI_EN),   .evt(ev_nmi_en));
  strobe_edge u_edge_nmi_dis (.clk(CLK), .rst(RESET), .strobe(Z80_NMI_DIS),  .evt(ev_nmi_dis));

  localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       reply_q, reply_d;
  mb_status_t       status_q, status_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             nmi_n_q, nmi_n_d;

  // Next-state for latches, flags, overrun and NMI. Writes take priority over
  // the matching read; NMI disable takes priority over enable.
  always_comb begin
    cmd_d    = cmd_q;
    reply_d  = reply_q;
    status_d = status_q;
    ovr_d    = ovr_q;

    if (ev_z80_rd) status_d.pending = 1'b0;
    if (ev_m68k_wr) begin
      cmd_d            = M68K_DIN;
      status_d.pending = 1'b1;
      // A write racing the Z80 read is consumed cleanly, not an overrun.
      if (status_q.pending && !ev_z80_rd && !(&ovr_q)) ovr_d = ovr_q + OVR_ONE;
    end

    if (ev_m68k_rd) status_d.fresh = 1'b0;
    if (ev_z80_wr) begin
      reply_d        = Z80_DIN;
      status_d.fresh = 1'b1;
    end

    if (ev_nmi_en)  status_d.nmi_en = 1'b1;
    if (ev_nmi_dis) status_d.nmi_en = 1'b0;

    // Computed from next-state so NMI moves on the same edge as the event.
    nmi_n_d = ~(status_d.pending & status_d.nmi_en);
  end

  // State registers; reset drops everything immediately, including NMI.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cmd_q    <= CMD_INIT;
      reply_q  <= CMD_INIT;
      status_q <= '0;
      ovr_q    <= '0;
      nmi_n_q  <= 1'b1;
    end else begin
      cmd_q    <= cmd_d;
      reply_q  <= reply_d;
      status_q <= status_d;
      ovr_q    <= ovr_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

  assign Z80_CMD     = cmd_q;
  assign M68K_DOUT   = reply_q;
  assign CMD_PENDING = status_q.pending;
  assign REPLY_FRESH = status_q.fresh;
  assign OVERRUN     = ovr_q;
  assign nZ80NMI     = nmi_n_q;

endmodule

// File: tb/tb_sound_mailbox.sv
// Testbench for sound_mailbox: directed scenarios plus randomized strobes
// compared against an event-level reference model.
module tb_sound_mailbox;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       M68K_WR = 1'b0;
  logic [7:0] M68K_DIN = 8'h00;
  logic       M68K_RD = 1'b0;
  logic [7:0] M68K_DOUT;
  logic       Z80_CMD_RD = 1'b0;
  logic [7:0] Z80_CMD;
  logic       Z80_REPLY_WR = 1'b0;
  logic [7:0] Z80_DIN = 8'h00;
  logic       Z80_NMI_EN = 1'b0;
  logic       Z80_NMI_DIS = 1'b0;
  logic       nZ80NMI;
  logic       CMD_PENDING;
  logic       REPLY_FRESH;
  logic [3:0] OVERRUN;

  int checks = 0;
  int errors = 0;

  sound_mailbox dut (
    .CLK(CLK), .RESET(RESET),
    .M68K_WR(M68K_WR), .M68K_DIN(M68K_DIN), .M68K_RD(M68K_RD), .M68K_DOUT(M68K_DOUT),
    .Z80_CMD_RD(Z80_CMD_RD), .Z80_CMD(Z80_CMD),
    .Z80_REPLY_WR(Z80_REPLY_WR), .Z80_DIN(Z80_DIN),
    .Z80_NMI_EN(Z80_NMI_EN), .Z80_NMI_DIS(Z80_NMI_DIS),
    .nZ80NMI(nZ80NMI), .CMD_PENDING(CMD_PENDING), .REPLY_FRESH(REPLY_FRESH),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Reference model: mailbox contents and the previous strobe levels.
  logic [7:0] m_cmd, m_reply;
  bit         m_pend, m_fresh, m_en;
  int         m_ovr;
  bit         p_wr, p_rd, p_crd, p_rwr, p_en, p_dis;

  function automatic void model_reset();
    m_cmd = 8'h00; m_reply = 8'h00;
    m_pend = 0; m_fresh = 0; m_en = 0; m_ovr = 0;
    p_wr = 0; p_rd = 0; p_crd = 0; p_rwr = 0; p_en = 0; p_dis = 0;
  endfunction

  function automatic bit model_nmi_n();
    return !(m_pend && m_en);
  endfunction

  // Apply one clock's worth of events seen on the current input levels.
  function automatic void model_clock();
    bit e_wr, e_rd, e_crd, e_rwr, e_en, e_dis;
    e_wr  = M68K_WR      && !p_wr;
    e_rd  = M68K_RD      && !p_rd;
    e_crd = Z80_CMD_RD   && !p_crd;
    e_rwr = Z80_REPLY_WR && !p_rwr;
    e_en  = Z80_NMI_EN   && !p_en;
    e_dis = Z80_NMI_DIS  && !p_dis;
    if (e_wr) begin
      if (m_pend && !e_crd && m_ovr < 15) m_ovr++;
      m_cmd = M68K_DIN;
      m_pend = 1;
    end else if (e_crd) m_pend = 0;
    if (e_rwr) begin
      m_reply = Z80_DIN;
      m_fresh = 1;
    end else if (e_rd) m_fresh = 0;
    if (e_dis) m_en = 0;
    else if (e_en) m_en = 1;
    p_wr = M68K_WR; p_rd = M68K_RD; p_crd = Z80_CMD_RD;
    p_rwr = Z80_REPLY_WR; p_en = Z80_NMI_EN; p_dis = Z80_NMI_DIS;
  endfunction

  // Advance one clock; outputs are stable when this returns.
  task automatic tick();
    model_clock();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    checks++; if (nZ80NMI !== 1'b1) begin errors++; $display("FAIL reset_nmi got %b want 1", nZ80NMI); end
    checks++; if (Z80_CMD !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h want 00", Z80_CMD); end
    checks++; if (M68K_DOUT !== 8'h00) begin errors++; $display("FAIL reset_reply got %h want 00", M68K_DOUT); end
    checks++; if ({CMD_PENDING, REPLY_FRESH, OVERRUN} !== 6'b0) begin errors++;
      $display("FAIL reset_flags got %b%b%h want 000", CMD_PENDING, REPLY_FRESH, OVERRUN); end
    do_reset();
  endtask

  task automatic test_cmd_nmi();
    do_reset();
    M68K_DIN = 8'h5A; M68K_WR = 1'b1; tick();
    checks++; if (Z80_CMD !== 8'h5A) begin errors++; $display("FAIL cmd_latch got %h want 5a", Z80_CMD); end
    checks++; if (CMD_PENDING !== 1'b1) begin errors++; $display("FAIL cmd_pending got %b want 1", CMD_PENDING); end
    checks++; if (nZ80NMI !== 1'b1) begin errors++; $display("FAIL nmi_disabled got %b want 1", nZ80NMI); end
    M68K_WR = 1'b0; tick();
    Z80_NMI_EN = 1'b1; tick();
    checks++; if (nZ80NMI !== 1'b0) begin errors++; $display("FAIL nmi_enable_pending got %b want 0", nZ80NMI); end
    Z80_NMI_EN = 1'b0; tick();
    Z80_NMI_DIS = 1'b1; tick();
    checks++; if (nZ80NMI !== 1'b1 || CMD_PENDING !== 1'b1) begin errors++;
      $display("FAIL nmi_disable got nmi=%b pend=%b want nmi=1 pend=1", nZ80NMI, CMD_PENDING); end
    Z80_NMI_DIS = 1'b0; tick();
  endtask

  task automatic test_nmi_read();
    do_reset();
    Z80_NMI_EN = 1'b1; tick(); Z80_NMI_EN = 1'b0; tick();
    checks++; if (nZ80NMI !== 1'b1) begin errors++; $display("FAIL nmi_idle got %b want 1", nZ80NMI); end
    M68K_DIN = 8'h01; M68K_WR = 1'b1; tick();
    checks++; if (nZ80NMI !== 1'b0 || CMD_PENDING !== 1'b1) begin errors++;
      $display("FAIL nmi_on_write got nmi=%b pend=%b want 0 1", nZ80NMI, CMD_PENDING); end
    M68K_WR = 1'b0; tick();
    Z80_CMD_RD = 1'b1; tick();
    checks++; if (nZ80NMI !== 1'b1 || CMD_PENDING !== 1'b0 || OVERRUN !== 4'h0) begin errors++;
      $display("FAIL nmi_after_read got nmi=%b pend=%b ovr=%h want 1 0 0", nZ80NMI, CMD_PENDING, OVERRUN); end
    Z80_CMD_RD = 1'b0; tick();
  endtask

  task automatic test_overrun();
    logic [7:0] last;
    do_reset();
    last = 8'h00;
    for (int i = 0; i < 20; i++) begin
      last = 8'($urandom);
      M68K_DIN = last; M68K_WR = 1'b1; tick();
      M68K_WR = 1'b0; tick();
    end
    checks++; if (OVERRUN !== 4'hF) begin errors++; $display("FAIL overrun_sat got %h want f", OVERRUN); end
    checks++; if (Z80_CMD !== last) begin errors++; $display("FAIL overrun_last got %h want %h", Z80_CMD, last); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] ovr_before;
    do_reset();
    M68K_DIN = 8'h11; M68K_WR = 1'b1; tick(); M68K_WR = 1'b0; tick();
    ovr_before = OVERRUN;
    M68K_DIN = 8'h22; M68K_WR = 1'b1; Z80_CMD_RD = 1'b1; tick();
    checks++; if (CMD_PENDING !== 1'b1 || Z80_CMD !== 8'h22) begin errors++;
      $display("FAIL wr_rd_same got pend=%b cmd=%h want 1 22", CMD_PENDING, Z80_CMD); end
    checks++; if (OVERRUN !== 4'h0 || OVERRUN !== ovr_before) begin errors++;
      $display("FAIL wr_rd_ovr got %h want 0", OVERRUN); end
    M68K_WR = 1'b0; Z80_CMD_RD = 1'b0; tick();
    Z80_NMI_EN = 1'b1; Z80_NMI_DIS = 1'b1; tick();
    checks++; if (nZ80NMI !== 1'b1) begin errors++; $display("FAIL en_dis_same got %b want 1", nZ80NMI); end
    Z80_NMI_EN = 1'b0; Z80_NMI_DIS = 1'b0; tick();
    Z80_NMI_EN = 1'b1; tick(); Z80_NMI_EN = 1'b0;
    checks++; if (nZ80NMI !== 1'b0) begin errors++; $display("FAIL en_after_same got %b want 0", nZ80NMI); end
    tick();
    Z80_DIN = 8'h3C; Z80_REPLY_WR = 1'b1; M68K_RD = 1'b1; tick();
    checks++; if (REPLY_FRESH !== 1'b1 || M68K_DOUT !== 8'h3C) begin errors++;
      $display("FAIL rwr_rd_same got fresh=%b dout=%h want 1 3c", REPLY_FRESH, M68K_DOUT); end
    Z80_REPLY_WR = 1'b0; M68K_RD = 1'b0; tick();
  endtask

  task automatic test_reply();
    do_reset();
    Z80_DIN = 8'hC3; Z80_REPLY_WR = 1'b1; tick();
    checks++; if (M68K_DOUT !== 8'hC3 || REPLY_FRESH !== 1'b1) begin errors++;
      $display("FAIL reply_write got dout=%h fresh=%b want c3 1", M68K_DOUT, REPLY_FRESH); end
    // Keep the write strobe high: it must not fire again after the read.
    for (int i = 0; i < 9; i++) tick();
    M68K_RD = 1'b1; tick();
    checks++; if (REPLY_FRESH !== 1'b0) begin errors++; $display("FAIL reply_read got %b want 0", REPLY_FRESH); end
    for (int i = 0; i < 9; i++) tick();
    checks++; if (REPLY_FRESH !== 1'b0 || M68K_DOUT !== 8'hC3) begin errors++;
      $display("FAIL reply_held got fresh=%b dout=%h want 0 c3", REPLY_FRESH, M68K_DOUT); end
    Z80_REPLY_WR = 1'b0; M68K_RD = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    Z80_DIN = 8'h99; Z80_REPLY_WR = 1'b1; Z80_NMI_EN = 1'b1; tick();
    Z80_REPLY_WR = 1'b0; Z80_NMI_EN = 1'b0; tick();
    M68K_DIN = 8'hA5; M68K_WR = 1'b1; tick(); M68K_WR = 1'b0; tick();
    M68K_WR = 1'b1; tick(); M68K_WR = 1'b0; tick();
    checks++; if (nZ80NMI !== 1'b0 || CMD_PENDING !== 1'b1) begin errors++;
      $display("FAIL pre_reset got nmi=%b pend=%b want 0 1", nZ80NMI, CMD_PENDING); end
    #2 RESET = 1'b1;
    #1;
    checks++; if (nZ80NMI !== 1'b1 || Z80_CMD !== 8'h00 || M68K_DOUT !== 8'h00) begin errors++;
      $display("FAIL async_reset got nmi=%b cmd=%h dout=%h want 1 00 00", nZ80NMI, Z80_CMD, M68K_DOUT); end
    checks++; if (CMD_PENDING !== 1'b0 || REPLY_FRESH !== 1'b0 || OVERRUN !== 4'h0) begin errors++;
      $display("FAIL async_flags got %b %b %h want 0 0 0", CMD_PENDING, REPLY_FRESH, OVERRUN); end
    // A write strobe held through reset release counts once on the first clock.
    M68K_DIN = 8'h77; M68K_WR = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    tick();
    checks++; if (CMD_PENDING !== 1'b1 || Z80_CMD !== 8'h77 || OVERRUN !== 4'h0) begin errors++;
      $display("FAIL held_through_reset got pend=%b cmd=%h ovr=%h want 1 77 0", CMD_PENDING, Z80_CMD, OVERRUN); end
    tick();
    checks++; if (OVERRUN !== 4'h0) begin errors++; $display("FAIL held_no_repeat got %h want 0", OVERRUN); end
    M68K_WR = 1'b0; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      M68K_DIN     = 8'($urandom);
      Z80_DIN      = 8'($urandom);
      M68K_WR      = ($urandom_range(0, 2) == 0);
      M68K_RD      = ($urandom_range(0, 2) == 0);
      Z80_CMD_RD   = ($urandom_range(0, 3) == 0);
      Z80_REPLY_WR = ($urandom_range(0, 2) == 0);
      Z80_NMI_EN   = ($urandom_range(0, 3) == 0);
      Z80_NMI_DIS  = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (Z80_CMD !== m_cmd || M68K_DOUT !== m_reply || CMD_PENDING !== m_pend ||
          REPLY_FRESH !== m_fresh || OVERRUN !== 4'(m_ovr) || nZ80NMI !== model_nmi_n()) begin
        errors++;
        $display("FAIL random_%0d got cmd=%h rep=%h pend=%b fresh=%b ovr=%h nmi=%b want %h %h %b %b %h %b",
                 i, Z80_CMD, M68K_DOUT, CMD_PENDING, REPLY_FRESH, OVERRUN, nZ80NMI,
                 m_cmd, m_reply, m_pend, m_fresh, 4'(m_ovr), model_nmi_n());
      end
    end
    M68K_WR = 0; M68K_RD = 0; Z80_CMD_RD = 0; Z80_REPLY_WR = 0; Z80_NMI_EN = 0; Z80_NMI_DIS = 0;
    tick();
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_cmd_nmi();
    test_nmi_read();
    test_overrun();
    test_simultaneous();
    test_reply();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_mailbox.md
# sound_mailbox

Bidirectional byte mailbox between the 68k main CPU and the Z80 sound CPU.
- 68k→Z80: the 68k writes a sound command, which raises a pending flag and drives the Z80 NMI when enabled.
- Z80→68k: the Z80 writes a reply byte, which the 68k reads back.
- Sits in the system glue between the 68k bus decoder (sound register) and the Z80 I/O port decoder (command read, reply write, NMI enable/disable ports).

## Interface
Parameters:
- OVR_W, 4: width of the saturating command-overrun counter.
- CMD_INIT, 8'h00: reset value of the command and reply latches.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high; clears all state immediately.
- M68K_WR  in  1  68k command-write strobe (level, synchronous to CLK).
- M68K_DIN  in  8  command byte; sampled on M68K_WR rising edge.
- M68K_RD  in  1  68k reply-read strobe (level).
- M68K_DOUT  out  8  reply latch contents.
- Z80_CMD_RD  in  1  Z80 command-read strobe (level).
- Z80_CMD  out  8  command latch contents.
- Z80_REPLY_WR  in  1  Z80 reply-write strobe (level).
- Z80_DIN  in  8  reply byte; sampled on Z80_REPLY_WR rising edge.
- Z80_NMI_EN  in  1  Z80 NMI-enable port strobe (level).
- Z80_NMI_DIS  in  1  Z80 NMI-disable port strobe (level).
- nZ80NMI  out  1  active-low NMI to Z80, registered.
- CMD_PENDING  out  1  command written and not yet read by Z80.
- REPLY_FRESH  out  1  reply written and not yet read by 68k.
- OVERRUN  out  OVR_W  count of 68k writes made while CMD_PENDING=1, saturating.

## Operation
- Every strobe is rising-edge detected: previous level is registered; an event is one cycle where strobe=1 and previous=0. A held strobe is one event.
- Command write event: cmd latch <= M68K_DIN; CMD_PENDING <= 1. If CMD_PENDING was already 1, OVERRUN increments, saturating at all-ones.
- Z80 command-read event: CMD_PENDING <= 0.
- Reply write event: reply latch <= Z80_DIN; REPLY_FRESH <= 1.
- 68k reply-read event: REPLY_FRESH <= 0.
- NMI enable flag: set by Z80_NMI_EN event, cleared by Z80_NMI_DIS event. If both events occur in the same cycle, disable wins.
- nZ80NMI <= ~(CMD_PENDING_next & nmi_en_next), registered.
  - Enabling NMI while a command is pending asserts NMI.
  - Disabling NMI deasserts it but keeps the command pending.
- Simultaneous events:
  - Command write and Z80 read in the same cycle: write wins; CMD_PENDING stays 1; no overrun increment.
  - Reply write and 68k read in the same cycle: write wins; REPLY_FRESH stays 1.
- Reset values:
  - Both latches = CMD_INIT.
  - CMD_PENDING=0, REPLY_FRESH=0, OVERRUN=0.
  - NMI enable=0, nZ80NMI=1.
  - Edge-detect history=0, so a strobe held high through reset release counts as one event on the first clock.
- Reset asserted mid-operation aborts all pending state with no residual NMI.

## Timing
- Strobe rising at edge N (sampled high at N, low at N-1):
  - Latch and flag updates are visible after edge N (1-cycle latency).
  - nZ80NMI falls after edge N (same edge; the registered output is computed from the next-state flags).
- M68K_DOUT and Z80_CMD are direct latch outputs with no read latency; a value written at edge N is readable from edge N.
- Minimum strobe spacing: low for at least 1 cycle between events.
- OVERRUN updates on the same edge as the offending write.

## Structure
- Shared package (sound_pkg): CMD_INIT default, OVR_W default, and a mailbox-status struct {pending, fresh, nmi_en}.
- Sub-module strobe_edge (registered previous level, one-cycle event output, async reset to 0), instantiated once per strobe (six).
- Top level holds the latches, flags, overrun counter and NMI register.

## Test plan
- Reset, then 68k write 8'h5A with NMI disabled -> Z80_CMD=8'h5A, CMD_PENDING=1, nZ80NMI=1; pulse Z80_NMI_EN -> nZ80NMI=0 one edge later.
- NMI enabled, write 8'h01, then Z80_CMD_RD -> nZ80NMI 0 then 1; CMD_PENDING 1 then 0; OVERRUN=0.
- Twenty 68k writes with no Z80 read -> OVERRUN=4'hF (saturated), Z80_CMD equals the last byte.
- Command write and Z80 read on the same edge -> CMD_PENDING=1, OVERRUN unchanged; with NMI enable and disable on the same edge -> nmi_en=0.
- Z80 writes 8'hC3, then 68k read -> M68K_DOUT=8'hC3, REPLY_FRESH 1 then 0; strobe held 10 cycles counts once.
- RESET pulsed while CMD_PENDING=1 and nZ80NMI=0 -> immediately nZ80NMI=1, latches=8'h00, all flags 0 without a clock edge.
